// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a small transmit FIFO, own baud divider and per-frame
// configuration (parity mode, stop bits) latched when a word is loaded.
module uart_tx_fifo_cfg #(
  parameter int unsigned N_DATA_BITS  = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          i_uart_clk,
  input  logic                          i_uart_reset_n,
  input  logic                          i_uart_en,
  input  logic                          i_uart_data_valid,
  input  logic [N_DATA_BITS-1:0]        i_uart_data,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  output logic                          o_uart_ready,
  output logic                          o_uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_uart_tx
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(N_DATA_BITS);

  localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  BitMax   = BitW'(N_DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and pointers
  logic [N_DATA_BITS-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ready_q;
  logic                   push, pop;

  // Transmit engine state
  state_e                 state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [N_DATA_BITS-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   two_stop_q, two_stop_d;
  logic                   stop2_q, stop2_d;
  logic                   start_frame;
  logic                   bit_end;
  logic [N_DATA_BITS-1:0] head_word;

  assign push      = i_uart_data_valid && ready_q;
  assign head_word = fifo_mem_q[rd_ptr_q];
  assign bit_end   = (baud_q == BaudMax);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_uart_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= i_uart_data;
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_uart_reset_n) begin
    if (!i_uart_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != DepthCnt);
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    par_en_d    = par_en_q;
    par_bit_d   = par_bit_q;
    two_stop_d  = two_stop_q;
    stop2_d     = stop2_q;
    start_frame = 1'b0;
    pop         = 1'b0;

    if (i_uart_en) begin
      unique case (state_q)
        StIdle: begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
          if (count_q != '0) start_frame = 1'b1;
        end
        StStart: begin
          if (bit_end) begin
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = shift_q[0];
            state_d = StData;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        StData: begin
          if (bit_end) begin
            baud_d = '0;
            if (bit_q == BitMax) begin
              if (par_en_q) begin
                tx_d    = par_bit_q;
                state_d = StParity;
              end else begin
                tx_d    = 1'b1;
                stop2_d = 1'b0;
                state_d = StStop;
              end
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        StParity: begin
          if (bit_end) begin
            baud_d  = '0;
            tx_d    = 1'b1;
            stop2_d = 1'b0;
            state_d = StStop;
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        StStop: begin
          if (bit_end) begin
            baud_d = '0;
            if (two_stop_q && !stop2_q) begin
              stop2_d = 1'b1;
            end else if (count_q != '0) begin
              // Chain straight into the next start bit, no idle gap.
              start_frame = 1'b1;
            end else begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = StIdle;
            end
          end else begin
            baud_d = baud_q + 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      endcase

      // Frame load: configuration is sampled only here.
      if (start_frame) begin
        pop        = 1'b1;
        shift_d    = head_word;
        par_en_d   = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
        par_bit_d  = (i_parity_mode == 2'b10) ? ~^head_word : ^head_word;
        two_stop_d = i_two_stop;
        stop2_d    = 1'b0;
        baud_d     = '0;
        bit_d      = '0;
        tx_d       = 1'b0;
        busy_d     = 1'b1;
        state_d    = StStart;
      end
    end
  end

  always_ff @(posedge i_uart_clk or negedge i_uart_reset_n) begin
    if (!i_uart_reset_n) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop2_q    <= stop2_d;
    end
  end

  assign o_uart_tx    = tx_q;
  assign o_uart_busy  = busy_q;
  assign o_uart_ready = ready_q;
  assign o_fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Directed bench for uart_tx_fifo_cfg (8 data bits, 16 clocks per bit, 4-word FIFO).
module tb_uart_tx_fifo_cfg;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       valid;
  logic [7:0] data;
  logic [1:0] mode;
  logic       two;
  logic       ready;
  logic       busy;
  logic [2:0] count;
  logic       tx;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_fifo_cfg #(
    .N_DATA_BITS (8),
    .CLKS_PER_BIT(16),
    .FIFO_DEPTH  (4)
  ) dut (
    .i_uart_clk       (clk),
    .i_uart_reset_n   (rst_n),
    .i_uart_en        (en),
    .i_uart_data_valid(valid),
    .i_uart_data      (data),
    .i_parity_mode    (mode),
    .i_two_stop       (two),
    .o_uart_ready     (ready),
    .o_uart_busy      (busy),
    .o_fifo_count     (count),
    .o_uart_tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Sample tx (and busy) on each of the next n falling edges.
  task automatic check_level(input string tag, input logic lvl, input int n, input logic exp_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, 32'(tx), 32'(lvl));
      check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic has_par,
                             input logic par_bit, input logic two_st, input int start_n);
    check_level({tag, "_start"}, 1'b0, start_n, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_level({tag, "_data"}, d[i], 16, 1'b1);
    end
    if (has_par) check_level({tag, "_parity"}, par_bit, 16, 1'b1);
    check_level({tag, "_stop"}, 1'b1, two_st ? 32 : 16, 1'b1);
  endtask

  task automatic push(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  logic [7:0] w3 [6];

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    valid = 1'b0;
    data  = 8'h00;
    mode  = 2'b00;
    two   = 1'b0;
    w3    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    #12;
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 0xA5, no parity, one stop
    push(8'hA5);
    check("t1_lat_tx", 32'(tx), 1);
    check("t1_lat_busy", 32'(busy), 0);
    check_frame("t1", 8'hA5, 1'b0, 1'b0, 1'b0, 16);
    check_level("t1_idle", 1'b1, 20, 1'b0);

    // 2: even parity then odd parity with two stop bits
    mode = 2'b01;
    push(8'h07);
    check_frame("t2_even", 8'h07, 1'b1, 1'b1, 1'b0, 16);
    @(negedge clk);
    check("t2_even_done", 32'(busy), 0);
    mode = 2'b10;
    two  = 1'b1;
    push(8'h07);
    check_frame("t2_odd", 8'h07, 1'b1, 1'b0, 1'b1, 16);
    @(negedge clk);
    check("t2_odd_done", 32'(busy), 0);
    mode = 2'b00;
    two  = 1'b0;
    @(negedge clk);

    // 3: six back-to-back writes, sixth refused while full
    data  = w3[0];
    valid = 1'b1;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      data = w3[i];
    end
    @(negedge clk);
    check("t3_count_full", 32'(count), 4);
    check("t3_ready_full", 32'(ready), 0);
    valid = 1'b0;
    check_frame("t3_f0", w3[0], 1'b0, 1'b0, 1'b0, 11);
    for (int i = 1; i < 5; i++) begin
      check_frame("t3_fn", w3[i], 1'b0, 1'b0, 1'b0, 16);
    end
    @(negedge clk);
    check("t3_done_busy", 32'(busy), 0);
    check("t3_done_count", 32'(count), 0);
    check("t3_done_ready", 32'(ready), 1);
    check_level("t3_idle", 1'b1, 20, 1'b0);

    // 4: reset during data bit 3 with a word still queued
    push(8'h00);
    push(8'hFF);
    check("t4_count", 32'(count), 1);
    check_level("t4_start", 1'b0, 15, 1'b1);
    check_level("t4_bits", 1'b0, 48, 1'b1);
    check_level("t4_bit3", 1'b0, 5, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_tx", 32'(tx), 1);
    check("t4_rst_count", 32'(count), 0);
    check("t4_rst_ready", 32'(ready), 1);
    check("t4_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_level("t4_after", 1'b1, 40, 1'b0);
    check("t4_after_count", 32'(count), 0);

    // 5: enable low for 10 cycles during data bit 2 of 0x5A
    push(8'h5A);
    check_level("t5_start", 1'b0, 16, 1'b1);
    check_level("t5_b0", 1'b0, 16, 1'b1);
    check_level("t5_b1", 1'b1, 16, 1'b1);
    check_level("t5_b2a", 1'b0, 5, 1'b1);
    en = 1'b0;
    check_level("t5_b2frz", 1'b0, 10, 1'b1);
    en = 1'b1;
    check_level("t5_b2b", 1'b0, 11, 1'b1);
    check_level("t5_b3", 1'b1, 16, 1'b1);
    check_level("t5_b4", 1'b1, 16, 1'b1);
    check_level("t5_b5", 1'b0, 16, 1'b1);
    check_level("t5_b6", 1'b1, 16, 1'b1);
    check_level("t5_b7", 1'b0, 16, 1'b1);
    check_level("t5_stop", 1'b1, 16, 1'b1);
    @(negedge clk);
    check("t5_done", 32'(busy), 0);

    // 6: parity mode changed mid-frame applies only to the next load
    data  = 8'h3C;
    valid = 1'b1;
    @(negedge clk);
    data = 8'h07;
    @(negedge clk);
    valid = 1'b0;
    mode  = 2'b01;
    check_frame("t6_f0", 8'h3C, 1'b0, 1'b0, 1'b0, 15);
    check_frame("t6_f1", 8'h07, 1'b1, 1'b1, 1'b0, 16);
    @(negedge clk);
    check("t6_done", 32'(busy), 0);
    check("t6_tx", 32'(tx), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
